// File: rtl/maze_seq_if.sv
// UART command handshake between the BLE receiver and the maze sequencer.
// master drives the byte and its valid, slave returns the one-cycle acknowledge.
interface maze_seq_if;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       clr_cmd_rdy;

  modport master (output cmd_rdy, output cmd, input clr_cmd_rdy);
  modport slave  (input cmd_rdy, input cmd, output clr_cmd_rdy);
endinterface

// File: rtl/maze_seq.sv
// Maze-turn sequencer: 4-deep turn queue, line-loss veer/settle FSM, bump halt; outputs registered, cmd acked 1 cycle after cmd_rdy.
// Full queue drops the byte but still acks; MAZE_TIMEOUT_EN adds a veer timeout that halts with buzzer.
module maze_seq #(
  parameter bit          FAST_SIM = 1'b1,
  parameter logic [15:0] VEER_MAG = 16'h0340
) (
  input  logic               clk,
  input  logic               rst_n,
  maze_seq_if.slave          cmd_if,
  input  logic               line_present,
  input  logic               BMPL_n,
  input  logic               BMPR_n,
  output logic               go,
  output logic signed [15:0] err_opn_lp,
  output logic               buzz_en,
  output logic [2:0]         q_cnt
);

  localparam logic [18:0] SETTLE_LAST = FAST_SIM ? 19'd255 : 19'h3FFFF;
`ifdef MAZE_TIMEOUT_EN
  localparam logic [26:0] TIMEOUT_LAST = FAST_SIM ? 27'd65535 : 27'h3FFFFFF;
  logic [26:0] veer_tmr;
`endif

  typedef enum logic [2:0] {IDLE, FOLLOW, VEER, SETTLE, HALT} state_t;
  state_t state;

  logic [1:0]  mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [1:0]  bl_sync, br_sync;
  logic [18:0] settle_tmr;
  logic        bmp, push_req, push_ok, pop;
  logic [1:0]  head;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_if.cmd[7:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_sync <= 2'b11;
      br_sync <= 2'b11;
    end else begin
      bl_sync <= {bl_sync[0], BMPL_n};
      br_sync <= {br_sync[0], BMPR_n};
    end
  end

  assign bmp      = ~bl_sync[1] | ~br_sync[1];
  assign push_req = cmd_if.cmd_rdy & ~cmd_if.clr_cmd_rdy;
  assign push_ok  = push_req & (q_cnt != 3'd4) & ~bmp;
  assign pop      = (state == FOLLOW) & ~line_present & (q_cnt != 3'd0) & ~bmp;
  assign head     = mem[rd_ptr];

  // Ack is independent of whether the byte was stored (full or bump).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr             <= 2'd0;
      wr_ptr             <= 2'd0;
      q_cnt              <= 3'd0;
      cmd_if.clr_cmd_rdy <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= 2'b00;
    end else begin
      cmd_if.clr_cmd_rdy <= push_req;
      if (bmp) begin
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
        q_cnt  <= 3'd0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= cmd_if.cmd[1:0];
          wr_ptr      <= wr_ptr + 2'd1;
        end
        if (pop) rd_ptr <= rd_ptr + 2'd1;
        case ({push_ok, pop})
          2'b10:   q_cnt <= q_cnt + 3'd1;
          2'b01:   q_cnt <= q_cnt - 3'd1;
          default: q_cnt <= q_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      go         <= 1'b0;
      err_opn_lp <= '0;
      buzz_en    <= 1'b0;
      settle_tmr <= '0;
`ifdef MAZE_TIMEOUT_EN
      veer_tmr   <= '0;
`endif
    end else if (bmp) begin
      state      <= HALT;
      go         <= 1'b0;
      err_opn_lp <= '0;
      buzz_en    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (q_cnt != 3'd0 && line_present) begin
            state <= FOLLOW;
            go    <= 1'b1;
          end
        end
        FOLLOW: begin
          if (!line_present) begin
            if (q_cnt == 3'd0 || head == 2'b00) begin
              state      <= HALT;
              go         <= 1'b0;
              err_opn_lp <= '0;
              buzz_en    <= 1'b0;
            end else begin
              state <= VEER;
`ifdef MAZE_TIMEOUT_EN
              veer_tmr <= '0;
`endif
              case (head)
                2'b01:   err_opn_lp <= $signed(-VEER_MAG);
                2'b10:   err_opn_lp <= $signed(VEER_MAG);
                default: err_opn_lp <= '0;
              endcase
            end
          end
        end
        VEER: begin
          if (line_present) begin
            state      <= SETTLE;
            settle_tmr <= '0;
          end
`ifdef MAZE_TIMEOUT_EN
          else if (veer_tmr == TIMEOUT_LAST) begin
            state      <= HALT;
            go         <= 1'b0;
            err_opn_lp <= '0;
            buzz_en    <= 1'b1;
          end else begin
            veer_tmr <= veer_tmr + 27'd1;
          end
`endif
        end
        SETTLE: begin
          // Veer timer keeps its count across a brief re-loss of the line.
          if (!line_present) begin
            state      <= VEER;
            settle_tmr <= '0;
          end else if (settle_tmr == SETTLE_LAST) begin
            state      <= FOLLOW;
            err_opn_lp <= '0;
          end else begin
            settle_tmr <= settle_tmr + 19'd1;
          end
        end
        HALT: begin
          if (push_ok) begin
            state   <= IDLE;
            buzz_en <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          go         <= 1'b0;
          err_opn_lp <= '0;
          buzz_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/maze_seq.md
# maze_seq

Maze-turn sequencer between the BLE command path and the PID/error mux. It buffers up to four turn commands received over UART. While the line is present it enables line following. When the line is lost it pops the next command and drives `err_opn_lp`/`go` to veer left, veer right, go straight or stop until the line is reacquired and stable. Bump switches force an immediate halt with buzzer.

## Interface
Parameters:
- `FAST_SIM`, default 1: shortens timers for fullchip simulation.
- `VEER_MAG`, default 16'h0340: magnitude of open-loop steering error.

Ports:
- `clk`  in  1  50 MHz system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_rdy`  in  1  UART byte available
- `cmd`  in  8  command byte; only `cmd[1:0]` used: 00 stop, 01 veer left, 10 veer right, 11 straight
- `clr_cmd_rdy`  out  1  one-cycle pulse acknowledging `cmd`
- `line_present`  in  1  from IR interface
- `BMPL_n`, `BMPR_n`  in  1 each  raw bump switches, async, active-low
- `go`  out  1  enables PID/motors
- `err_opn_lp`  out  16  signed steering error; veer left = -VEER_MAG, veer right = +VEER_MAG
- `buzz_en`  out  1  buzzer enable
- `q_cnt`  out  3  queue occupancy 0..4, for LEDs

## Operation
- Queue: 4-entry circular FIFO, 2 bits wide, with 2-bit rd/wr pointers that wrap 3→0.
  - `cmd_rdy` high and `clr_cmd_rdy` low: push `cmd[1:0]` and pulse `clr_cmd_rdy` the next cycle.
  - Queue full: the byte is dropped, but `clr_cmd_rdy` still pulses.
  - Push and pop in the same cycle: both occur and `q_cnt` is unchanged.
  - A bump clears the queue: pointers and `q_cnt` go to 0, and a push in that same cycle is discarded.
- Bump inputs: each is double-flop synchronized; `bmp` = either synchronized input low.
- State machine, all outputs registered:
  - IDLE: `go`=0, `err_opn_lp`=0. Move to FOLLOW when `q_cnt`≠0 and `line_present`.
  - FOLLOW: `go`=1, `err_opn_lp`=0. When `line_present`=0, pop the head.
    - 00 → HALT.
    - 01/10/11 → VEER, with `err_opn_lp` = -VEER_MAG / +VEER_MAG / 0.
    - Queue empty → HALT, no pop.
  - VEER: `go`=1, hold `err_opn_lp`, run the veer timer. `line_present`=1 → SETTLE with the settle timer cleared.
  - SETTLE: `go`=1, hold `err_opn_lp`.
    - Line drops → return to VEER; the settle timer clears and the veer timer is not cleared.
    - Settle timer reaches SETTLE_CYC → FOLLOW with `err_opn_lp`=0.
  - HALT: `go`=0, `err_opn_lp`=0. `buzz_en`=1 only if HALT was entered via bump or timeout. Move to IDLE on the first push after entry.
- `bmp` in any state → HALT next cycle with `buzz_en`=1, and the queue is cleared. `bmp` takes priority over all other transitions.
- Timers, unsigned, saturating, cleared on state entry:
  - SETTLE_CYC = FAST_SIM ? 2^8 : 2^18.
  - TIMEOUT_CYC = FAST_SIM ? 2^16 : 2^26.

## Timing
- Reset values:
  - state IDLE
  - `go`=0, `err_opn_lp`=0, `clr_cmd_rdy`=0, `buzz_en`=0, `q_cnt`=0
  - pointers 0, timers 0, sync flops 1
- `line_present` falling in FOLLOW → VEER with the new `err_opn_lp` on the next clock edge. The pop is in the same cycle.
- `cmd_rdy` → `q_cnt` increments 1 cycle later, and `clr_cmd_rdy` pulses 1 cycle later.
- Bump edge → `go`=0 within 3 clocks (2 sync + 1 state).
- Reset asserted mid-operation returns immediately to the reset values; the queue contents are lost.

## Configuration
- `MAZE_TIMEOUT_EN` defined: veer-timer saturation at TIMEOUT_CYC in VEER forces HALT with `buzz_en`=1.
- Not defined: the timer logic is removed and VEER waits indefinitely for `line_present`.

## Test plan
- Push 01 with the line present → FOLLOW, `go`=1; drop the line → `err_opn_lp`=16'hFCC0 next cycle; restore the line for 256 cycles (FAST_SIM) → FOLLOW, `err_opn_lp`=0, `q_cnt`=0.
- Push 5 commands 10,10,11,01,00 → `q_cnt`=4, 5th dropped, five `clr_cmd_rdy` pulses; four line losses pop 10,10,11,01 in order; fifth line loss with an empty queue → HALT, `buzz_en`=0.
- In SETTLE, toggle the line low after 100 cycles → VEER, direction held; then hold the line high 256 cycles → FOLLOW.
- `BMPR_n`=0 during VEER with `q_cnt`=3 → `go`=0 within 3 clocks, `buzz_en`=1, `q_cnt`=0; push 11 → IDLE, `buzz_en`=0.
- With `MAZE_TIMEOUT_EN`, hold the line low 65536 cycles in VEER → HALT, `buzz_en`=1; without it, the block stays in VEER with `go`=1.
- Push and line loss in the same cycle at `q_cnt`=2 → pop and push both occur, `q_cnt` stays 2.
